i2c_master_arbiter: RTL and testbench

- Shares one i2c_master among NUM_REQ on-chip requesters using round-robin arbitration.
- Each winning request is issued as a single write or read command to the master.
- The arbiter waits for the master's completion, then returns read data and ACK status to the winning requester.
- Sits between client logic and the i2c_master instance; drives that instance's write/read/addr/data_wr/speed_mode inputs.

---
 rtl/i2c_arb_pkg.sv | 23 ++
 rtl/i2c_master_arbiter_if.sv | 42 ++++
 rtl/i2c_master_arbiter_rr_arbiter.sv | 31 +++
 rtl/i2c_master_arbiter.sv | 120 ++++++++++++
 tb/tb_i2c_master_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared constants and types for the i2c_master_arbiter block.
// Contents: FSM state encodings (IDLE/ISSUE/WAIT/RESP), operand widths,
// and the latched command record carried through one transaction.
// Optional feature macro used by the top: I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int SPEED_W = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Winner's operands, frozen at grant so the master inputs stay stable
  // even if the requester drops its request mid-transaction.
  typedef struct packed {
    logic               rd;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [SPEED_W-1:0] speed;
  } arb_cmd_t;
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and master-side signals of i2c_master_arbiter.
// modport master : the arbiter (drives gnt/rsp_*/mst_* command outputs).
// modport slave  : the surrounding logic (requesters + i2c_master instance).
// Signals: speed_mode, req, req_rd, req_addr (7b packed per requester),
// req_data (8b packed), gnt, rsp_done, rsp_data, rsp_err, mst_write,
// mst_read, mst_speed, mst_addr, mst_data_wr, mst_data_rd, mst_done,
// mst_ack_error.
interface i2c_master_arbiter_if #(parameter int NUM_REQ = 4);
  import i2c_arb_pkg::*;

  logic [SPEED_W-1:0]        speed_mode;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_done;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      mst_write;
  logic                      mst_read;
  logic [SPEED_W-1:0]        mst_speed;
  logic [ADDR_W-1:0]         mst_addr;
  logic [DATA_W-1:0]         mst_data_wr;
  logic [DATA_W-1:0]         mst_data_rd;
  logic                      mst_done;
  logic                      mst_ack_error;

  modport master (
    input  speed_mode, req, req_rd, req_addr, req_data,
           mst_data_rd, mst_done, mst_ack_error,
    output gnt, rsp_done, rsp_data, rsp_err,
           mst_write, mst_read, mst_speed, mst_addr, mst_data_wr
  );

  modport slave (
    output speed_mode, req, req_rd, req_addr, req_data,
           mst_data_rd, mst_done, mst_ack_error,
    input  gnt, rsp_done, rsp_data, rsp_err,
           mst_write, mst_read, mst_speed, mst_addr, mst_data_wr
  );
endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: i_req (request vector), i_ptr (highest-priority index),
// o_gnt (one-hot winner), o_idx (winner index), o_vld (any request).
// Searches from i_ptr upward, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_vld
);
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_j = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (!o_vld && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one i2c_master among NUM_REQ requesters with
// round-robin arbitration; one byte write or read per grant.
// Ports: clk, rst (synchronous, active low), bus (i2c_master_arbiter_if.master).
// Optional macro I2C_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES cycles
// with rsp_err=1; without it WAIT waits for mst_done indefinitely.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_master_arbiter_if.master  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("i2c_master_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_gnt;
  arb_cmd_t           r_cmd;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  arb_cmd_t           w_sel;
  logic               w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // Operand mux for the current pick; loop form keeps all selects constant.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel.rd   = bus.req_rd[i];
        w_sel.addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel.data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    w_sel.speed = bus.speed_mode;
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_tcnt;
  // Counter holds k in the k-th WAIT cycle, so RESP starts exactly
  // TIMEOUT_CYCLES cycles after WAIT entry.
  assign w_timeout = (r_tcnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst)                  r_tcnt <= '0;
    else if (r_state == ISSUE) r_tcnt <= '0;
    else if (r_state == WAIT)  r_tcnt <= r_tcnt + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_gnt      <= '0;
      r_cmd      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_idx   <= w_pick_idx;
          r_gnt   <= w_pick_gnt;
          r_cmd   <= w_sel;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (bus.mst_done) begin
            r_rsp_data <= r_cmd.rd ? bus.mst_data_rd : '0;
            r_rsp_err  <= bus.mst_ack_error;
            r_state    <= RESP;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          r_ptr   <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
          r_gnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rsp_done    = (r_state == RESP) ? r_gnt : '0;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.mst_write   = (r_state == ISSUE) && !r_cmd.rd;
  assign bus.mst_read    = (r_state == ISSUE) &&  r_cmd.rd;
  assign bus.mst_speed   = r_cmd.speed;
  assign bus.mst_addr    = r_cmd.addr;
  assign bus.mst_data_wr = r_cmd.data;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed, table-driven bench for i2c_master_arbiter (NUM_REQ=4,
// TIMEOUT_CYCLES=20). Inputs are driven and outputs sampled on negedge.
module tb_i2c_master_arbiter;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  i2c_master_arbiter_if #(.NUM_REQ(4)) bus ();

  i2c_master_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic [6:0] abase;   // requester i uses abase+i
    logic [7:0] dbase;   // requester i uses dbase^i
    logic [1:0] spd;
    logic [7:0] mrd;     // master read data returned
    logic       merr;    // master ack_error returned
    logic [3:0] e_gnt;
    logic [6:0] e_addr;
    logic [7:0] e_data;
    logic [7:0] e_rsp;
    logic       e_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != 4'b0) break;
    end
    if (bus.gnt == 4'b0) lat = 99;
  endtask

  task automatic drive_ops(input vec_t v);
    bus.req_rd     = {4{v.rd}};
    bus.req_addr   = {v.abase + 7'd3, v.abase + 7'd2, v.abase + 7'd1, v.abase};
    bus.req_data   = {v.dbase ^ 8'd3, v.dbase ^ 8'd2, v.dbase ^ 8'd1, v.dbase};
    bus.speed_mode = v.spd;
  endtask

  task automatic run_row(input int r);
    vec_t v;
    int   lat;
    v = tbl[r];
    drive_ops(v);
    bus.req = v.req;
    wait_gnt(lat);
    chk($sformatf("row%0d latency", r), lat, 1);
    if (lat == 99) return;
    chk($sformatf("row%0d gnt", r), bus.gnt, v.e_gnt);
    chk($sformatf("row%0d mst_write", r), bus.mst_write, !v.rd);
    chk($sformatf("row%0d mst_read", r), bus.mst_read, v.rd);
    chk($sformatf("row%0d mst_addr", r), bus.mst_addr, v.e_addr);
    chk($sformatf("row%0d mst_data_wr", r), bus.mst_data_wr, v.e_data);
    chk($sformatf("row%0d mst_speed", r), bus.mst_speed, v.spd);
    @(negedge clk);  // WAIT
    chk($sformatf("row%0d pulse_end", r), {bus.mst_write, bus.mst_read}, 0);
    chk($sformatf("row%0d gnt_held", r), bus.gnt, v.e_gnt);
    @(negedge clk);
    bus.mst_done      = 1'b1;
    bus.mst_data_rd   = v.mrd;
    bus.mst_ack_error = v.merr;
    @(negedge clk);  // RESP
    bus.mst_done      = 1'b0;
    bus.mst_ack_error = 1'b0;
    chk($sformatf("row%0d rsp_done", r), bus.rsp_done, v.e_gnt);
    chk($sformatf("row%0d rsp_data", r), bus.rsp_data, v.e_rsp);
    chk($sformatf("row%0d rsp_err", r), bus.rsp_err, v.e_err);
    chk($sformatf("row%0d addr_stable", r), bus.mst_addr, v.e_addr);
    bus.req = 4'b0;
    @(negedge clk);  // back in IDLE
    chk($sformatf("row%0d idle_done", r), bus.rsp_done, 0);
    chk($sformatf("row%0d idle_gnt", r), bus.gnt, 0);
  endtask

  initial begin
    int   lat;
    logic seen;
    //          req     rd  abase  dbase  spd    mrd    merr e_gnt   e_addr e_data e_rsp  e_err
    tbl[0] = '{4'b0010, 0, 7'h4F, 8'hA4, 2'b01, 8'h77, 0, 4'b0010, 7'h50, 8'hA5, 8'h00, 0};
    tbl[1] = '{4'b0100, 1, 7'h1F, 8'h00, 2'b10, 8'h3C, 0, 4'b0100, 7'h21, 8'h02, 8'h3C, 0};
    tbl[2] = '{4'b1000, 0, 7'h30, 8'h10, 2'b11, 8'h5A, 1, 4'b1000, 7'h33, 8'h13, 8'h00, 1};
    tbl[3] = '{4'b0001, 1, 7'h40, 8'h55, 2'b00, 8'hC3, 0, 4'b0001, 7'h40, 8'h55, 8'hC3, 0};
    tbl[4] = '{4'b1111, 0, 7'h60, 8'h20, 2'b01, 8'h00, 0, 4'b0001, 7'h60, 8'h20, 8'h00, 0};
    tbl[5] = '{4'b1111, 1, 7'h60, 8'h20, 2'b10, 8'h9A, 0, 4'b0010, 7'h61, 8'h21, 8'h9A, 0};
    tbl[6] = '{4'b1111, 0, 7'h60, 8'h20, 2'b11, 8'h11, 0, 4'b0100, 7'h62, 8'h22, 8'h00, 0};
    tbl[7] = '{4'b1111, 1, 7'h60, 8'h20, 2'b00, 8'hE7, 0, 4'b1000, 7'h63, 8'h23, 8'hE7, 0};
    tbl[8] = '{4'b1111, 0, 7'h60, 8'h20, 2'b01, 8'h00, 0, 4'b0001, 7'h60, 8'h20, 8'h00, 0};
    tbl[9] = '{4'b0011, 0, 7'h60, 8'h20, 2'b01, 8'h00, 0, 4'b0010, 7'h61, 8'h21, 8'h00, 0};

    rst = 1'b0;
    bus.req = '0; bus.req_rd = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.speed_mode = '0; bus.mst_data_rd = '0; bus.mst_done = 1'b0;
    bus.mst_ack_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset gnt", bus.gnt, 0);
    chk("reset rsp_done", bus.rsp_done, 0);
    chk("reset pulses", {bus.mst_write, bus.mst_read}, 0);
    chk("reset regs", {bus.rsp_data, bus.rsp_err, bus.mst_addr, bus.mst_data_wr, bus.mst_speed}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single write, single read, ack error, recovery (pointer ends at 1)
    for (int r = 0; r < 4; r++) run_row(r);

    // reset asserted during WAIT drops the transaction
    drive_ops('{4'b0100, 0, 7'h70, 8'h44, 2'b11, 8'h00, 0, 4'b0100, 7'h72, 8'h46, 8'h00, 0});
    bus.req = 4'b0100;
    wait_gnt(lat);
    chk("rstwait gnt", bus.gnt, 4'b0100);
    @(negedge clk);  // WAIT
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait gnt_clr", bus.gnt, 0);
    chk("rstwait regs", {bus.rsp_data, bus.rsp_err, bus.mst_addr, bus.mst_data_wr}, 0);
    rst = 1'b1;
    bus.req = 4'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | (bus.rsp_done != 4'b0);
    end
    chk("rstwait no_rsp_done", seen, 0);

    // done pulse while idle must be ignored
    bus.mst_done = 1'b1;
    @(negedge clk);
    bus.mst_done = 1'b0;
    @(negedge clk);
    chk("idle_done ignored", {bus.gnt, bus.rsp_done}, 0);

    // all four requesting from pointer 0, then served requester re-requests
    for (int r = 4; r < 10; r++) run_row(r);

`ifdef I2C_ARB_TIMEOUT_EN
    drive_ops(tbl[4]);
    bus.req = 4'b0001;
    wait_gnt(lat);
    chk("timeout gnt", bus.gnt, 4'b0001);
    lat = 0;
    while (lat < 100 && bus.rsp_done == 4'b0) begin
      @(negedge clk);
      lat++;
    end
    bus.req = 4'b0;
    chk("timeout latency", lat, 21);
    chk("timeout rsp_done", bus.rsp_done, 4'b0001);
    chk("timeout rsp_err", bus.rsp_err, 1);
    chk("timeout rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    bus.mst_done = 1'b1;
    @(negedge clk);
    bus.mst_done = 1'b0;
    @(negedge clk);
    chk("timeout late_done", {bus.gnt, bus.rsp_done}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
